ram_sincrona_param: RTL and testbench
=====================================

Name: ram_sincrona_param

Overview:
Parametrised single-port synchronous RAM; next generation of the 8x256 synchronous RAM.
Adds configurable data/address width and depth, selectable read-during-write mode, 1- or 2-cycle read latency with a valid strobe, and an out-of-range address flag.
Adds a hardware clear sequencer that fills the array with VALOR_INICIAL after reset or on request.
Used as the generic data/scratch memory for the datapath blocks.

Parameters:
ANCHO_DATO, 8, data width in bits
ANCHO_DIR, 8, address width in bits
PROFUNDIDAD, 256, number of words (1..2**ANCHO_DIR)
LATENCIA, 1, read latency in clk cycles (1 or 2)
MODO, 0, read-during-write: 0 = read-first (old data), 1 = write-first (new data), 2 = no-change
VALOR_INICIAL, 0, word written to every address by the clear sequence

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
limpiar  input  1  one-cycle request to re-run the clear sequence
acceso  input  1  access qualifier; operation performed only when 1
EN  input  1  1 = write, 0 = read (when acceso=1)
direccion  input  ANCHO_DIR  word address
dato_e  input  ANCHO_DATO  write data
dato_s  output  ANCHO_DATO  read data, registered
valido  output  1  dato_s carries the result of an access issued LATENCIA cycles earlier
ocupado  output  1  clear sequence running; accesses ignored
error_dir  output  1  pulse aligned with valido: the access had direccion >= PROFUNDIDAD

Behaviour:
- Reset (rst=1, asynchronous): dato_s=0, valido=0, error_dir=0, ocupado=1, FSM=LIMPIANDO, clear counter=0. Array contents are not touched during reset; they are overwritten by the sweep.
- FSM states: LIMPIANDO, LISTO.
- LIMPIANDO: each rising edge writes mem[contador]=VALOR_INICIAL and increments contador.
  - On the edge that writes PROFUNDIDAD-1: go to LISTO; ocupado=0 after that edge.
  - After rst release, ocupado is therefore high for exactly PROFUNDIDAD rising edges.
- LISTO with limpiar=1: next edge enters LIMPIANDO, contador=0, ocupado=1.
- limpiar=1 during LIMPIANDO: contador restarts at 0 on that edge.
- ocupado=1: acceso is ignored (no write, no valido). Reads already in the latency pipeline still complete.
- Access accepted on an edge with acceso=1, ocupado=0 and direccion < PROFUNDIDAD:
  - EN=1: mem[direccion]=dato_e on that edge.
    - MODO 0: dato_s=old word, valido=1.
    - MODO 1: dato_s=dato_e, valido=1.
    - MODO 2: dato_s holds its value, valido=0.
  - EN=0: dato_s=mem[direccion], valido=1.
- Latency:
  - LATENCIA=1: result in dato_s/valido after the accepting edge.
  - LATENCIA=2: one extra output register stage; valido/error_dir pipelined identically. Back-to-back accesses give one result per cycle.
- valido is a one-cycle strobe per access. With no access, valido=0 and dato_s holds its value.
- direccion >= PROFUNDIDAD: write suppressed; reads (and writes in MODO 0/1) return dato_s=0 with valido=1, error_dir=1. In MODO 2 a write produces error_dir=1 with valido=0.
- rst asserted mid-sweep or mid-access: immediate return to reset values; the pipeline is flushed and the sweep restarts from address 0.
- Width rules: dato_e and dato_s are exactly ANCHO_DATO bits wide. contador is ANCHO_DIR bits wide and never reaches PROFUNDIDAD.

Test Plan:
1. Defaults; rst pulse then release -> ocupado=1 for 256 edges then 0; read dir 0 and dir 255 -> dato_s=0, valido=1 one cycle after each.
2. Write 64 to dir 0, then 12 to dir 1; then read dir 0, 1, 3 back-to-back -> dato_s 64, 12, 0 on consecutive cycles, valido=1 each.
3. dir 0 holds 64; write 0x55 to dir 0: MODO=0 -> dato_s=64, valido=1; MODO=1 -> dato_s=0x55; MODO=2 -> dato_s unchanged, valido=0. A subsequent read returns 0x55 in every mode.
4. LATENCIA=2: reads dir 0, 1 issued on consecutive edges -> 64 and 12 appear 2 cycles after their issue edge; valido high for exactly 2 cycles.
5. PROFUNDIDAD=200: write 0xAA to dir 210 -> error_dir=1, array unchanged; read dir 210 -> dato_s=0, valido=1, error_dir=1; dir 199 still works normally.
6. After writes, pulse limpiar -> ocupado=1 for 256 edges and a write issued mid-sweep is ignored; then dir 0 and dir 1 read VALOR_INICIAL. Assert rst at sweep edge 100 -> outputs reset immediately and the sweep restarts full length.

Source files
------------

// File: rtl/ram_sincrona_param.sv
`default_nettype none
// ============================================================================
// Module      : ram_sincrona_param
// Description : Parametrised single-port synchronous RAM with clear sequencer,
//               selectable read-during-write mode and 1/2-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sincrona_param #(
  parameter int                    ANCHO_DATO    = 8,
  parameter int                    ANCHO_DIR     = 8,
  parameter int                    PROFUNDIDAD   = 256,
  parameter int                    LATENCIA      = 1,
  parameter int                    MODO          = 0,
  parameter logic [ANCHO_DATO-1:0] VALOR_INICIAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  limpiar,
  input  logic                  acceso,
  input  logic                  EN,
  input  logic [ANCHO_DIR-1:0]  direccion,
  input  logic [ANCHO_DATO-1:0] dato_e,
  output logic [ANCHO_DATO-1:0] dato_s,
  output logic                  valido,
  output logic                  ocupado,
  output logic                  error_dir
);

  localparam int                   c_ultima      = PROFUNDIDAD - 1;
  localparam logic [ANCHO_DIR-1:0] c_ultima_dir  = c_ultima[ANCHO_DIR-1:0];
  localparam logic [ANCHO_DIR:0]   c_profundidad = PROFUNDIDAD[ANCHO_DIR:0];

  typedef enum logic [0:0] {
    LIMPIANDO = 1'b0,
    LISTO     = 1'b1
  } estado_t;

  estado_t               r_estado;
  logic [ANCHO_DIR-1:0]  r_contador;
  logic                  r_ocupado;

  logic [ANCHO_DATO-1:0] r_mem [PROFUNDIDAD];

  logic                  w_acepta;
  logic                  w_en_rango;
  logic [ANCHO_DATO-1:0] w_lectura;
  logic                  w_escribe;
  logic [ANCHO_DIR-1:0]  w_dir_esc;
  logic [ANCHO_DATO-1:0] w_dato_esc;

  logic [ANCHO_DATO-1:0] r_dato1;
  logic                  r_valido1;
  logic                  r_error1;

  // The extra bit keeps the range check exact when PROFUNDIDAD == 2**ANCHO_DIR.
  assign w_en_rango = ({1'b0, direccion} < c_profundidad);
  assign w_acepta   = acceso && !r_ocupado;
  assign w_lectura  = r_mem[direccion];
  assign ocupado    = r_ocupado;

  // Clear sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado   <= LIMPIANDO;
      r_contador <= '0;
      r_ocupado  <= 1'b1;
    end else begin
      case (r_estado)
        LIMPIANDO: begin
          if (limpiar) begin
            r_contador <= '0;
          end else if (r_contador == c_ultima_dir) begin
            r_estado   <= LISTO;
            r_contador <= '0;
            r_ocupado  <= 1'b0;
          end else begin
            r_contador <= r_contador + 1'b1;
          end
        end
        LISTO: begin
          if (limpiar) begin
            r_estado   <= LIMPIANDO;
            r_contador <= '0;
            r_ocupado  <= 1'b1;
          end
        end
        default: begin
          r_estado   <= LIMPIANDO;
          r_contador <= '0;
          r_ocupado  <= 1'b1;
        end
      endcase
    end
  end

  // The sweep owns the write port while busy; otherwise an accepted in-range write.
  always_comb begin
    w_escribe  = 1'b0;
    w_dir_esc  = direccion;
    w_dato_esc = dato_e;
    if (r_estado == LIMPIANDO) begin
      w_escribe  = 1'b1;
      w_dir_esc  = r_contador;
      w_dato_esc = VALOR_INICIAL;
    end else if (w_acepta && EN && w_en_rango) begin
      w_escribe  = 1'b1;
    end
  end

  // Array has no reset; rst only blocks writes so contents survive until swept.
  always_ff @(posedge clk) begin
    if (w_escribe && !rst) begin
      r_mem[w_dir_esc] <= w_dato_esc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dato1   <= '0;
      r_valido1 <= 1'b0;
      r_error1  <= 1'b0;
    end else begin
      r_valido1 <= 1'b0;
      r_error1  <= 1'b0;
      if (w_acepta) begin
        if (!w_en_rango) begin
          r_error1 <= 1'b1;
          if (!EN || (MODO != 2)) begin
            r_dato1   <= '0;
            r_valido1 <= 1'b1;
          end
        end else if (!EN) begin
          r_dato1   <= w_lectura;
          r_valido1 <= 1'b1;
        end else if (MODO == 0) begin
          r_dato1   <= w_lectura;
          r_valido1 <= 1'b1;
        end else if (MODO == 1) begin
          r_dato1   <= dato_e;
          r_valido1 <= 1'b1;
        end
      end
    end
  end

  generate
    if (LATENCIA == 2) begin : g_latencia2
      logic [ANCHO_DATO-1:0] r_dato2;
      logic                  r_valido2;
      logic                  r_error2;

      // Data only advances with a valid result so dato_s holds between accesses.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_dato2   <= '0;
          r_valido2 <= 1'b0;
          r_error2  <= 1'b0;
        end else begin
          r_valido2 <= r_valido1;
          r_error2  <= r_error1;
          if (r_valido1) begin
            r_dato2 <= r_dato1;
          end
        end
      end

      assign dato_s    = r_dato2;
      assign valido    = r_valido2;
      assign error_dir = r_error2;
    end else begin : g_latencia1
      assign dato_s    = r_dato1;
      assign valido    = r_valido1;
      assign error_dir = r_error1;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_sincrona_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sincrona_param
// Description : Five RAM configurations driven by shared stimulus, each checked
//               against its own array/queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sincrona_param;

  localparam int N = 5;
  localparam int P_PROF [N] = '{256, 256, 256, 256, 200};
  localparam int P_LAT  [N] = '{1, 1, 1, 2, 1};
  localparam int P_MODO [N] = '{0, 1, 2, 0, 0};
  localparam int P_INI  [N] = '{0, 0, 0, 0, 8'h3C};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       limpiar, acceso, en;
  logic [7:0] dir, din;
  logic [7:0] q [N];
  logic       v [N];
  logic       e [N];
  logic       b [N];

  int checks = 0;
  int failures = 0;

  int m_mem [N][256];
  bit m_busy [N];
  int m_cnt [N];
  bit prev_v [N];
  bit prev_e [N];
  int prev_d [N];
  int exp_d [N];
  bit exp_v [N];
  bit exp_e [N];

  always #5 clk = ~clk;

  ram_sincrona_param u0 (.clk(clk), .rst(rst), .limpiar(limpiar), .acceso(acceso), .EN(en),
    .direccion(dir), .dato_e(din), .dato_s(q[0]), .valido(v[0]), .ocupado(b[0]), .error_dir(e[0]));
  ram_sincrona_param #(.MODO(1)) u1 (.clk(clk), .rst(rst), .limpiar(limpiar), .acceso(acceso), .EN(en),
    .direccion(dir), .dato_e(din), .dato_s(q[1]), .valido(v[1]), .ocupado(b[1]), .error_dir(e[1]));
  ram_sincrona_param #(.MODO(2)) u2 (.clk(clk), .rst(rst), .limpiar(limpiar), .acceso(acceso), .EN(en),
    .direccion(dir), .dato_e(din), .dato_s(q[2]), .valido(v[2]), .ocupado(b[2]), .error_dir(e[2]));
  ram_sincrona_param #(.LATENCIA(2)) u3 (.clk(clk), .rst(rst), .limpiar(limpiar), .acceso(acceso), .EN(en),
    .direccion(dir), .dato_e(din), .dato_s(q[3]), .valido(v[3]), .ocupado(b[3]), .error_dir(e[3]));
  ram_sincrona_param #(.PROFUNDIDAD(200), .VALOR_INICIAL(8'h3C)) u4 (.clk(clk), .rst(rst),
    .limpiar(limpiar), .acceso(acceso), .EN(en), .direccion(dir), .dato_e(din), .dato_s(q[4]),
    .valido(v[4]), .ocupado(b[4]), .error_dir(e[4]));

  function automatic void model_reset(int k);
    m_busy[k] = 1'b1;
    m_cnt[k]  = 0;
    prev_v[k] = 1'b0;
    prev_e[k] = 1'b0;
    prev_d[k] = 0;
    exp_d[k]  = 0;
    exp_v[k]  = 1'b0;
    exp_e[k]  = 1'b0;
  endfunction

  // One rising edge of configuration k, using the inputs held across that edge.
  function automatic void model_step(int k);
    bit rv, re, vv, ve;
    int rd, vd, a;
    rv = 1'b0; re = 1'b0; rd = 0;
    a = int'(dir);
    if (!m_busy[k] && acceso) begin
      if (a < P_PROF[k]) begin
        if (en) begin
          if (P_MODO[k] == 0) begin rv = 1'b1; rd = m_mem[k][a]; end
          else if (P_MODO[k] == 1) begin rv = 1'b1; rd = int'(din); end
          m_mem[k][a] = int'(din);
        end else begin
          rv = 1'b1;
          rd = m_mem[k][a];
        end
      end else begin
        re = 1'b1;
        if (!(en && P_MODO[k] == 2)) begin rv = 1'b1; rd = 0; end
      end
    end
    if (m_busy[k]) begin
      m_mem[k][m_cnt[k]] = P_INI[k];
      if (limpiar) m_cnt[k] = 0;
      else if (m_cnt[k] == P_PROF[k] - 1) m_busy[k] = 1'b0;
      else m_cnt[k] = m_cnt[k] + 1;
    end else if (limpiar) begin
      m_busy[k] = 1'b1;
      m_cnt[k]  = 0;
    end
    if (P_LAT[k] == 1) begin
      vv = rv; ve = re; vd = rd;
    end else begin
      vv = prev_v[k]; ve = prev_e[k]; vd = prev_d[k];
      prev_v[k] = rv; prev_e[k] = re; prev_d[k] = rd;
    end
    exp_v[k] = vv;
    exp_e[k] = ve;
    if (vv) exp_d[k] = vd;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", tag, k, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk("dato_s", k, {24'd0, q[k]}, exp_d[k] & 255);
      chk("valido", k, {31'd0, v[k]}, {31'd0, exp_v[k]});
      chk("error_dir", k, {31'd0, e[k]}, {31'd0, exp_e[k]});
      chk("ocupado", k, {31'd0, b[k]}, {31'd0, m_busy[k]});
    end
  endtask

  task automatic set_in(input bit a, input bit w, input int ad, input int d, input bit lp);
    acceso  = a;
    en      = w;
    dir     = 8'(ad);
    din     = 8'(d);
    limpiar = lp;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (rst) model_reset(k);
      else model_step(k);
    end
    check_all();
  endtask

  task automatic op(input bit a, input bit w, input int ad, input int d);
    set_in(a, w, ad, d, 1'b0);
    tick();
  endtask

  task automatic wait_sweep(input int expected_edges);
    int n;
    n = 0;
    set_in(0, 0, 0, 0, 0);
    do begin
      tick();
      n++;
    end while (b[0] !== 1'b0 && n < 1000);
    chk("sweep_edges", 0, n, expected_edges);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < N; k++) model_reset(k);
    check_all();
    tick();
    rst = 1'b0;
    wait_sweep(256);

    // Fresh array reads back the clear value
    op(1, 0, 0, 0);   chk("rd0_after_clear", 0, {24'd0, q[0]}, 0);
                      chk("rd0_valid", 0, {31'd0, v[0]}, 1);
    op(1, 0, 255, 0); chk("rd255_after_clear", 0, {24'd0, q[0]}, 0);
                      chk("rd255_oor_err", 4, {31'd0, e[4]}, 1);
    op(0, 0, 0, 0);

    op(1, 1, 0, 64);
    op(1, 1, 1, 12);
    op(1, 0, 0, 0);   chk("rd_dir0", 0, {24'd0, q[0]}, 64);
    op(1, 0, 1, 0);   chk("rd_dir1", 0, {24'd0, q[0]}, 12);
    op(1, 0, 3, 0);   chk("rd_dir3", 0, {24'd0, q[0]}, 0);
                      chk("rd_dir3_valid", 0, {31'd0, v[0]}, 1);
    op(0, 0, 0, 0);
    op(0, 0, 0, 0);

    // Two-cycle latency instance
    op(1, 0, 0, 0);   chk("lat2_not_yet", 3, {31'd0, v[3]}, 0);
    op(1, 0, 1, 0);   chk("lat2_first", 3, {24'd0, q[3]}, 64);
    op(0, 0, 0, 0);   chk("lat2_second", 3, {24'd0, q[3]}, 12);
                      chk("lat2_second_valid", 3, {31'd0, v[3]}, 1);
    op(0, 0, 0, 0);   chk("lat2_done", 3, {31'd0, v[3]}, 0);

    // Read-during-write modes
    op(1, 1, 0, 8'h55);
    chk("rdw_read_first", 0, {24'd0, q[0]}, 64);
    chk("rdw_write_first", 1, {24'd0, q[1]}, 8'h55);
    chk("rdw_no_change", 2, {24'd0, q[2]}, 12);
    chk("rdw_no_change_valid", 2, {31'd0, v[2]}, 0);
    op(1, 0, 0, 0);
    chk("rdw_after_m0", 0, {24'd0, q[0]}, 8'h55);
    chk("rdw_after_m1", 1, {24'd0, q[1]}, 8'h55);
    chk("rdw_after_m2", 2, {24'd0, q[2]}, 8'h55);

    // Out-of-range address on the 200-word instance
    op(1, 1, 210, 8'hAA);
    chk("oor_wr_err", 4, {31'd0, e[4]}, 1);
    chk("oor_wr_dato", 4, {24'd0, q[4]}, 0);
    op(1, 0, 210, 0);
    chk("oor_rd_err", 4, {31'd0, e[4]}, 1);
    chk("oor_rd_valid", 4, {31'd0, v[4]}, 1);
    chk("inrange_210", 0, {24'd0, q[0]}, 8'hAA);
    op(1, 1, 199, 8'h77);
    op(1, 0, 199, 0);
    chk("last_word", 4, {24'd0, q[4]}, 8'h77);
    chk("last_word_err", 4, {31'd0, e[4]}, 0);

    // Requested clear with a write attempted mid-sweep
    set_in(0, 0, 0, 0, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) op(0, 0, 0, 0);
    op(1, 1, 0, 8'h99);
    chk("midsweep_no_valid", 0, {31'd0, v[0]}, 0);
    wait_sweep(245);
    op(1, 0, 0, 0);
    chk("clear_dir0", 0, {24'd0, q[0]}, 0);
    chk("clear_dir0_init", 4, {24'd0, q[4]}, 8'h3C);
    op(1, 0, 1, 0);
    chk("clear_dir1_init", 4, {24'd0, q[4]}, 8'h3C);
    op(0, 0, 0, 0);

    // Asynchronous reset part-way through a sweep
    set_in(0, 0, 0, 0, 1'b1);
    tick();
    set_in(0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 100; i++) tick();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) model_reset(k);
    check_all();
    tick();
    rst = 1'b0;
    wait_sweep(256);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
             int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
             $urandom_range(149, 0) == 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 300 && b[0] !== 1'b0; i++) tick();
    chk("drain_idle", 0, {31'd0, b[0]}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
